// File: rtl/iq_sample_packer.sv
// Packs 8-bit I/Q pairs two at a time into 32-bit A2F FIFO words, flushing a lone
// half word when capture is disabled, and counts words lost to a full FIFO.
module iq_sample_packer #(
  parameter int unsigned SAMPLE_WIDTH  = 8,
  parameter int unsigned FT_DATA_WIDTH = 32,
  parameter int unsigned DROP_CNT_W    = 16
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     enable,
  input  logic                     sample_valid,
  input  logic [SAMPLE_WIDTH-1:0]  sample_i,
  input  logic [SAMPLE_WIDTH-1:0]  sample_q,
  input  logic                     fifo_full,
  output logic                     fifo_wr_req,
  output logic [FT_DATA_WIDTH-1:0] fifo_wdata,
  output logic                     wr_incomming,
  output logic                     overflow,
  output logic [DROP_CNT_W-1:0]    drop_count,
  input  logic                     clear_stats
);

  localparam int unsigned HALF_W = 2 * SAMPLE_WIDTH;

  typedef enum logic {
    EMPTY = 1'b0,
    HALF  = 1'b1
  } state_t;

  state_t                     state;
  state_t                     state_d;
  logic [HALF_W-1:0]          half_q;
  logic [HALF_W-1:0]          half_d;
  logic                       accept_c;
  logic                       word_done_c;
  logic [FT_DATA_WIDTH-1:0]   word_c;

  assign accept_c = enable & sample_valid;

  // Next state and word assembly; a disable in HALF flushes pair A zero-padded.
  always_comb begin
    state_d     = state;
    half_d      = half_q;
    word_done_c = 1'b0;
    word_c      = '0;
    case (state)
      EMPTY: begin
        if (accept_c) begin
          half_d  = {sample_q, sample_i};
          state_d = HALF;
        end
      end
      HALF: begin
        if (accept_c) begin
          word_c      = FT_DATA_WIDTH'({sample_q, sample_i, half_q});
          word_done_c = 1'b1;
          state_d     = EMPTY;
        end else if (!enable) begin
          word_c      = FT_DATA_WIDTH'(half_q);
          word_done_c = 1'b1;
          state_d     = EMPTY;
        end
      end
      default: state_d = EMPTY;
    endcase
  end

  // State, partial word and registered FIFO write port.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= EMPTY;
      half_q      <= '0;
      fifo_wr_req <= 1'b0;
      fifo_wdata  <= '0;
    end else begin
      state       <= state_d;
      half_q      <= half_d;
      fifo_wr_req <= word_done_c & ~fifo_full;
      if (word_done_c && !fifo_full) begin
        fifo_wdata <= word_c;
      end
    end
  end

  // Drop statistics; clear beats a coincident drop.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      overflow   <= 1'b0;
      drop_count <= '0;
    end else if (clear_stats) begin
      overflow   <= 1'b0;
      drop_count <= '0;
    end else if (word_done_c && fifo_full) begin
      overflow <= 1'b1;
      if (drop_count != {DROP_CNT_W{1'b1}}) begin
        drop_count <= drop_count + DROP_CNT_W'(1);
      end
    end
  end

  assign wr_incomming = (state == HALF) | fifo_wr_req | accept_c;

endmodule

// File: tb/tb_iq_sample_packer.sv
// Directed bench for iq_sample_packer: a vector table for the main flows plus
// hand sequences for reset-mid-word and counter saturation/clear.
module tb_iq_sample_packer;

  logic        clk = 1'b0;
  logic        reset;
  logic        enable;
  logic        sample_valid;
  logic [7:0]  sample_i;
  logic [7:0]  sample_q;
  logic        fifo_full;
  logic        clear_stats;
  logic        fifo_wr_req;
  logic [31:0] fifo_wdata;
  logic        wr_incomming;
  logic        overflow;
  logic [15:0] drop_count;
  logic        s_wr_req;
  logic [31:0] s_wdata;
  logic        s_inc;
  logic        s_ovf;
  logic [1:0]  s_drop;

  always #5 clk = ~clk;

  iq_sample_packer dut (
    .clk(clk), .reset(reset), .enable(enable), .sample_valid(sample_valid),
    .sample_i(sample_i), .sample_q(sample_q), .fifo_full(fifo_full),
    .fifo_wr_req(fifo_wr_req), .fifo_wdata(fifo_wdata), .wr_incomming(wr_incomming),
    .overflow(overflow), .drop_count(drop_count), .clear_stats(clear_stats)
  );

  // Narrow counter instance so saturation is reachable in a few words.
  iq_sample_packer #(.DROP_CNT_W(2)) dut_s (
    .clk(clk), .reset(reset), .enable(enable), .sample_valid(sample_valid),
    .sample_i(sample_i), .sample_q(sample_q), .fifo_full(fifo_full),
    .fifo_wr_req(s_wr_req), .fifo_wdata(s_wdata), .wr_incomming(s_inc),
    .overflow(s_ovf), .drop_count(s_drop), .clear_stats(clear_stats)
  );

  typedef struct {
    logic        en;
    logic        vld;
    logic [7:0]  i;
    logic [7:0]  q;
    logic        full;
    logic        clr;
    logic        e_inc;
    logic        e_req;
    logic [31:0] e_data;
    logic [15:0] e_drop;
    logic        e_ovf;
  } vec_t;

  localparam logic H = 1'b1;
  localparam logic L = 1'b0;
  localparam int unsigned NV = 27;

  vec_t vecs [NV];
  int   errors = 0;
  int   checks = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic drive(input logic en, input logic vld, input logic [7:0] i, input logic [7:0] q,
                       input logic full, input logic clr);
    @(negedge clk);
    enable = en; sample_valid = vld; sample_i = i; sample_q = q;
    fifo_full = full; clear_stats = clr;
  endtask

  task automatic step(input vec_t v, input int idx);
    drive(v.en, v.vld, v.i, v.q, v.full, v.clr);
    #1;
    chk($sformatf("v%0d wr_incomming", idx), 32'(wr_incomming), 32'(v.e_inc));
    @(posedge clk);
    #1;
    chk($sformatf("v%0d fifo_wr_req", idx), 32'(fifo_wr_req), 32'(v.e_req));
    if (v.e_req) chk($sformatf("v%0d fifo_wdata", idx), fifo_wdata, v.e_data);
    chk($sformatf("v%0d drop_count", idx), 32'(drop_count), 32'(v.e_drop));
    chk($sformatf("v%0d overflow", idx), 32'(overflow), 32'(v.e_ovf));
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    enable = 1'b0; sample_valid = 1'b0; sample_i = '0; sample_q = '0;
    fifo_full = 1'b0; clear_stats = 1'b0;
    @(negedge clk);
    reset = 1'b0;
  endtask

  initial begin
    // {en, vld, i, q, full, clr, e_inc, e_req, e_data, e_drop, e_ovf}
    // back-to-back full words
    vecs[0]  = '{H, H, 8'h01, 8'h02, L, L, H, L, 32'h0, 16'd0, L};
    vecs[1]  = '{H, H, 8'h03, 8'h04, L, L, H, H, 32'h04030201, 16'd0, L};
    vecs[2]  = '{H, H, 8'h05, 8'h06, L, L, H, L, 32'h0, 16'd0, L};
    vecs[3]  = '{H, H, 8'h07, 8'h08, L, L, H, H, 32'h08070605, 16'd0, L};
    // lone pair then disable: zero-padded flush
    vecs[4]  = '{H, H, 8'hAA, 8'hBB, L, L, H, L, 32'h0, 16'd0, L};
    vecs[5]  = '{L, L, 8'h00, 8'h00, L, L, H, H, 32'h0000BBAA, 16'd0, L};
    vecs[6]  = '{L, L, 8'h00, 8'h00, L, L, H, L, 32'h0, 16'd0, L};
    vecs[7]  = '{L, L, 8'h00, 8'h00, L, L, L, L, 32'h0, 16'd0, L};
    // three dropped words, then full released
    vecs[8]  = '{H, H, 8'h11, 8'h12, H, L, H, L, 32'h0, 16'd0, L};
    vecs[9]  = '{H, H, 8'h13, 8'h14, H, L, H, L, 32'h0, 16'd1, H};
    vecs[10] = '{H, H, 8'h21, 8'h22, H, L, H, L, 32'h0, 16'd1, H};
    vecs[11] = '{H, H, 8'h23, 8'h24, H, L, H, L, 32'h0, 16'd2, H};
    vecs[12] = '{H, H, 8'h31, 8'h32, H, L, H, L, 32'h0, 16'd2, H};
    vecs[13] = '{H, H, 8'h33, 8'h34, H, L, H, L, 32'h0, 16'd3, H};
    vecs[14] = '{H, H, 8'h41, 8'h42, L, L, H, L, 32'h0, 16'd3, H};
    vecs[15] = '{H, H, 8'h43, 8'h44, L, L, H, H, 32'h44434241, 16'd3, H};
    // full only matters in the completing cycle
    vecs[16] = '{H, H, 8'h51, 8'h52, H, L, H, L, 32'h0, 16'd3, H};
    vecs[17] = '{H, H, 8'h53, 8'h54, L, L, H, H, 32'h54535251, 16'd3, H};
    vecs[18] = '{L, L, 8'h00, 8'h00, L, H, H, L, 32'h0, 16'd0, L};
    // gapped valid, one pair every third cycle
    vecs[19] = '{H, H, 8'h61, 8'h62, L, L, H, L, 32'h0, 16'd0, L};
    vecs[20] = '{H, L, 8'h00, 8'h00, L, L, H, L, 32'h0, 16'd0, L};
    vecs[21] = '{H, L, 8'h00, 8'h00, L, L, H, L, 32'h0, 16'd0, L};
    vecs[22] = '{H, H, 8'h63, 8'h64, L, L, H, H, 32'h64636261, 16'd0, L};
    vecs[23] = '{H, L, 8'h00, 8'h00, L, L, H, L, 32'h0, 16'd0, L};
    vecs[24] = '{H, L, 8'h00, 8'h00, L, L, L, L, 32'h0, 16'd0, L};
    // valid while disabled is ignored
    vecs[25] = '{L, H, 8'h77, 8'h78, L, L, L, L, 32'h0, 16'd0, L};
    vecs[26] = '{L, L, 8'h00, 8'h00, L, L, L, L, 32'h0, 16'd0, L};

    reset = 1'b1;
    enable = 1'b0; sample_valid = 1'b0; sample_i = '0; sample_q = '0;
    fifo_full = 1'b0; clear_stats = 1'b0;
    #1;
    chk("reset fifo_wr_req", 32'(fifo_wr_req), 32'd0);
    chk("reset fifo_wdata", fifo_wdata, 32'd0);
    chk("reset drop_count", 32'(drop_count), 32'd0);
    chk("reset overflow", 32'(overflow), 32'd0);
    chk("reset wr_incomming", 32'(wr_incomming), 32'd0);
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;

    for (int n = 0; n < int'(NV); n++) step(vecs[n], n);

    // reset pulse while a half word is held
    drive(H, H, 8'h91, 8'h92, L, L);
    @(posedge clk);
    @(negedge clk);
    reset = 1'b1; sample_valid = 1'b0;
    #1;
    chk("midreset fifo_wr_req", 32'(fifo_wr_req), 32'd0);
    chk("midreset fifo_wdata", fifo_wdata, 32'd0);
    chk("midreset s_wdata", s_wdata, 32'd0);
    chk("midreset wr_incomming", 32'(wr_incomming), 32'd0);
    @(posedge clk);
    #1;
    chk("midreset no write", 32'(fifo_wr_req), 32'd0);
    @(negedge clk);
    reset = 1'b0;
    drive(H, H, 8'hA1, 8'hA2, L, L);
    @(posedge clk); #1;
    chk("fresh word half req", 32'(fifo_wr_req), 32'd0);
    drive(H, H, 8'hB1, 8'hB2, L, L);
    @(posedge clk); #1;
    chk("fresh word req", 32'(fifo_wr_req), 32'd1);
    chk("fresh word data", fifo_wdata, 32'hB2B1A2A1);

    // saturation on the 2-bit counter, then clear coinciding with a drop
    do_reset();
    for (int k = 1; k <= 4; k++) begin
      drive(H, H, 8'(k), 8'h10, H, L);
      @(posedge clk);
      drive(H, H, 8'(k), 8'h20, H, L);
      #1;
      chk($sformatf("sat%0d s_wr_incomming", k), 32'(s_inc), 32'd1);
      @(posedge clk); #1;
      chk($sformatf("sat%0d drop_count", k), 32'(drop_count), 32'(k));
      chk($sformatf("sat%0d s_drop", k), 32'(s_drop), (k > 3) ? 32'd3 : 32'(k));
      chk($sformatf("sat%0d s_wr_req", k), 32'(s_wr_req), 32'd0);
    end
    chk("sat s_overflow", 32'(s_ovf), 32'd1);
    drive(H, H, 8'hC1, 8'hC2, H, L);
    @(posedge clk);
    drive(H, H, 8'hC3, 8'hC4, H, H);
    @(posedge clk); #1;
    chk("clrdrop drop_count", 32'(drop_count), 32'd0);
    chk("clrdrop overflow", 32'(overflow), 32'd0);
    chk("clrdrop s_drop", 32'(s_drop), 32'd0);
    chk("clrdrop s_overflow", 32'(s_ovf), 32'd0);
    chk("clrdrop fifo_wr_req", 32'(fifo_wr_req), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
